// File: rtl/knn_pkg.sv
// rtl/knn_pkg.sv - shared types, width helpers and constants for the k-NN sorter
//
// Contents:
//   knn_state_t : query FSM encoding (IDLE/RUN/DRAIN/DONE)
//   dist_w()    : squared-distance width for a given coordinate width
//   cnt_w()     : width of a 0..K fill counter
//   sel_w()     : width of a rank selector for K entries
//   DIST_INIT   : all-ones "empty slot" distance, sliced to DIST_W by users
package knn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } knn_state_t;

    localparam int DIST_MAX_W = 128;
    localparam logic [DIST_MAX_W-1:0] DIST_INIT = '1;

    function automatic int dist_w(input int data_w);
        return 2 * data_w + 1;
    endfunction

    function automatic int cnt_w(input int k);
        return $clog2(k + 1);
    endfunction

    function automatic int sel_w(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/knn_dist2.sv
// rtl/knn_dist2.sv - stage 1: registered per-axis difference squares with valid passthrough
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   flush             : drop the stage contents (query restart)
//   in_valid          : accepted training point this cycle
//   in_x, in_y        : signed training coordinates
//   tx, ty            : signed latched test coordinates
//   in_idx, in_label  : index and label carried alongside the point
//   out_valid         : stage holds a point
//   sq_x, sq_y        : unsigned squared differences, 2*DATA_W bits each
//   out_idx, out_label: carried index and label
module knn_dist2 #(
    parameter int DATA_W  = 16,
    parameter int IDX_W   = 8,
    parameter int LABEL_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic signed [DATA_W-1:0]  in_x,
    input  logic signed [DATA_W-1:0]  in_y,
    input  logic signed [DATA_W-1:0]  tx,
    input  logic signed [DATA_W-1:0]  ty,
    input  logic [IDX_W-1:0]          in_idx,
    input  logic [LABEL_W-1:0]        in_label,
    output logic                      out_valid,
    output logic [2*DATA_W-1:0]       sq_x,
    output logic [2*DATA_W-1:0]       sq_y,
    output logic [IDX_W-1:0]          out_idx,
    output logic [LABEL_W-1:0]        out_label
);

    logic signed [DATA_W:0]     dx;
    logic signed [DATA_W:0]     dy;
    logic signed [2*DATA_W-1:0] dx_w;
    logic signed [2*DATA_W-1:0] dy_w;

    // Differences need one extra bit so the full signed range never wraps.
    assign dx = {in_x[DATA_W-1], in_x} - {tx[DATA_W-1], tx};
    assign dy = {in_y[DATA_W-1], in_y} - {ty[DATA_W-1], ty};

    // The true square is below 2^(2*DATA_W), so a product truncated to that
    // width is exact and the sign of the difference does not matter.
    assign dx_w = {{(DATA_W-1){dx[DATA_W]}}, dx};
    assign dy_w = {{(DATA_W-1){dy[DATA_W]}}, dy};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sq_x      <= '0;
            sq_y      <= '0;
            out_idx   <= '0;
            out_label <= '0;
        end else begin
            out_valid <= in_valid & ~flush;
            if (in_valid) begin
                sq_x      <= dx_w * dx_w;
                sq_y      <= dy_w * dy_w;
                out_idx   <= in_idx;
                out_label <= in_label;
            end
        end
    end

endmodule

// File: rtl/knn_sorter_k.sv
// rtl/knn_sorter_k.sv - keeps the K nearest labelled training points to a test point
//
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   start, test_x, test_y      : begin/restart a query with a new test point
//   in_valid, in_ready         : training point handshake
//   in_x, in_y, in_label       : training point and its class label
//   in_last                    : final point of the query
//   busy, done                 : query in progress / result stable
//   count                      : filled entries, saturating at K
//   idx_ovf                    : sticky, more than 2^IDX_W points this query
//   rd_sel                     : rank to read, 0 = nearest
//   rd_dist, rd_idx, rd_label  : fields at that rank (reset values if empty)
//   rd_valid                   : rd_sel < count
module knn_sorter_k
    import knn_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int K       = 4,
    parameter int IDX_W   = 8,
    parameter int LABEL_W = 8,
    localparam int DIST_W = dist_w(DATA_W),
    localparam int CNT_W  = cnt_w(K),
    localparam int SEL_W  = sel_w(K)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] test_x,
    input  logic signed [DATA_W-1:0] test_y,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_x,
    input  logic signed [DATA_W-1:0] in_y,
    input  logic [LABEL_W-1:0]       in_label,
    input  logic                     in_last,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         count,
    output logic                     idx_ovf,
    input  logic [SEL_W-1:0]         rd_sel,
    output logic [DIST_W-1:0]        rd_dist,
    output logic [IDX_W-1:0]         rd_idx,
    output logic [LABEL_W-1:0]       rd_label,
    output logic                     rd_valid
);

    localparam logic [DIST_W-1:0] D_INIT = DIST_INIT[DIST_W-1:0];
    localparam logic [CNT_W-1:0]  K_CNT  = CNT_W'(K);

    knn_state_t              state;
    logic signed [DATA_W-1:0] tx;
    logic signed [DATA_W-1:0] ty;
    // One bit wider than the index so the first wrap is observable.
    logic [IDX_W:0]          idx_cnt;
    logic                    accept;

    logic                    s1_valid;
    logic [2*DATA_W-1:0]     s1_sq_x;
    logic [2*DATA_W-1:0]     s1_sq_y;
    logic [IDX_W-1:0]        s1_idx;
    logic [LABEL_W-1:0]      s1_label;
    logic [DIST_W-1:0]       new_dist;

    logic [DIST_W-1:0]       dist_q  [K];
    logic [IDX_W-1:0]        idx_q   [K];
    logic [LABEL_W-1:0]      label_q [K];
    logic [K-1:0]            ins;

    // A restart wins over a same-cycle handshake; that point is lost.
    assign accept = in_valid & in_ready & ~start;

    knn_dist2 #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W),
        .LABEL_W(LABEL_W)
    ) u_dist2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (start),
        .in_valid (accept),
        .in_x     (in_x),
        .in_y     (in_y),
        .tx       (tx),
        .ty       (ty),
        .in_idx   (idx_cnt[IDX_W-1:0]),
        .in_label (in_label),
        .out_valid(s1_valid),
        .sq_x     (s1_sq_x),
        .sq_y     (s1_sq_y),
        .out_idx  (s1_idx),
        .out_label(s1_label)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            in_ready <= 1'b0;
            tx       <= '0;
            ty       <= '0;
            idx_cnt  <= '0;
            idx_ovf  <= 1'b0;
        end else if (start) begin
            state    <= ST_RUN;
            busy     <= 1'b1;
            done     <= 1'b0;
            in_ready <= 1'b1;
            tx       <= test_x;
            ty       <= test_y;
            idx_cnt  <= '0;
            idx_ovf  <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (accept) begin
                        idx_cnt <= idx_cnt + 1'b1;
                        idx_ovf <= idx_ovf | idx_cnt[IDX_W];
                        if (in_last) begin
                            state    <= ST_DRAIN;
                            in_ready <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    // The insertion stage writes in the same cycle it sees
                    // stage 1 valid, so an empty stage 1 means fully drained.
                    if (!s1_valid) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign new_dist = {1'b0, s1_sq_x} + {1'b0, s1_sq_y};

    // Strict compare: an equal distance lands behind the existing entry, so
    // the earlier index keeps the lower rank.
    always_comb begin
        ins = '0;
        for (int i = 0; i < K; i++) begin
            ins[i] = new_dist < dist_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < K; i++) begin
                dist_q[i]  <= D_INIT;
                idx_q[i]   <= '0;
                label_q[i] <= '0;
            end
            count <= '0;
        end else if (start) begin
            for (int i = 0; i < K; i++) begin
                dist_q[i]  <= D_INIT;
                idx_q[i]   <= '0;
                label_q[i] <= '0;
            end
            count <= '0;
        end else if (s1_valid) begin
            if (ins[0]) begin
                dist_q[0]  <= new_dist;
                idx_q[0]   <= s1_idx;
                label_q[0] <= s1_label;
            end
            // The list is sorted, so ins is thermometer-coded: every entry at
            // or beyond the insertion point shifts down one rank.
            for (int i = 1; i < K; i++) begin
                if (ins[i-1]) begin
                    dist_q[i]  <= dist_q[i-1];
                    idx_q[i]   <= idx_q[i-1];
                    label_q[i] <= label_q[i-1];
                end else if (ins[i]) begin
                    dist_q[i]  <= new_dist;
                    idx_q[i]   <= s1_idx;
                    label_q[i] <= s1_label;
                end
            end
            // Empty slots hold all-ones, above any reachable distance, so
            // every point is inserted until the list is full.
            if (count != K_CNT) begin
                count <= count + 1'b1;
            end
        end
    end

    always_comb begin
        rd_valid = CNT_W'(rd_sel) < count;
        rd_dist  = D_INIT;
        rd_idx   = '0;
        rd_label = '0;
        if (rd_valid) begin
            rd_dist  = dist_q[rd_sel];
            rd_idx   = idx_q[rd_sel];
            rd_label = label_q[rd_sel];
        end
    end

endmodule

// File: tb/tb_knn_sorter_k.sv
// tb/tb_knn_sorter_k.sv - self-checking bench for knn_sorter_k
module tb_knn_sorter_k;

    localparam int K = 4;

    typedef struct {
        longint d;
        int     idx;
        int     idx_o;
        int     lab;
    } ent_t;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic signed [15:0] test_x, test_y;
    logic               in_valid, in_last;
    logic signed [15:0] in_x, in_y;
    logic [7:0]         in_label;
    logic [1:0]         rd_sel;

    logic        in_ready_a, busy_a, done_a, ovf_a, rd_valid_a;
    logic [2:0]  count_a;
    logic [32:0] rd_dist_a;
    logic [7:0]  rd_idx_a, rd_label_a;

    logic        in_ready_b, busy_b, done_b, ovf_b, rd_valid_b;
    logic [2:0]  count_b;
    logic [32:0] rd_dist_b;
    logic [3:0]  rd_idx_b;
    logic [7:0]  rd_label_b;

    int     vectors = 0;
    int     miscompares = 0;
    ent_t   model[$];
    int     n_acc = 0;
    longint m_tx = 0, m_ty = 0;
    bit     bp = 0;

    knn_sorter_k #(.DATA_W(16), .K(K), .IDX_W(8), .LABEL_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .test_x(test_x), .test_y(test_y),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_x(in_x), .in_y(in_y),
        .in_label(in_label), .in_last(in_last), .busy(busy_a), .done(done_a),
        .count(count_a), .idx_ovf(ovf_a), .rd_sel(rd_sel), .rd_dist(rd_dist_a),
        .rd_idx(rd_idx_a), .rd_label(rd_label_a), .rd_valid(rd_valid_a)
    );

    knn_sorter_k #(.DATA_W(16), .K(K), .IDX_W(4), .LABEL_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .test_x(test_x), .test_y(test_y),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_x(in_x), .in_y(in_y),
        .in_label(in_label), .in_last(in_last), .busy(busy_b), .done(done_b),
        .count(count_b), .idx_ovf(ovf_b), .rd_sel(rd_sel), .rd_dist(rd_dist_b),
        .rd_idx(rd_idx_b), .rd_label(rd_label_b), .rd_valid(rd_valid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Stable insertion into a sorted list truncated to K entries.
    task automatic model_accept(input int x, input int y, input int lab);
        ent_t   e;
        longint dx, dy;
        int     p;
        dx      = longint'(x) - m_tx;
        dy      = longint'(y) - m_ty;
        e.d     = dx * dx + dy * dy;
        e.idx   = n_acc % 256;
        e.idx_o = n_acc % 16;
        e.lab   = lab;
        n_acc++;
        p = model.size();
        for (int i = 0; i < model.size(); i++) begin
            if (model[i].d > e.d) begin
                p = i;
                break;
            end
        end
        model.insert(p, e);
        if (model.size() > K) void'(model.pop_back());
    endtask

    task automatic do_start(input int x, input int y);
        start  = 1'b1;
        test_x = 16'(x);
        test_y = 16'(y);
        cyc();
        start = 1'b0;
        model.delete();
        n_acc = 0;
        m_tx  = x;
        m_ty  = y;
    endtask

    task automatic send(input int x, input int y, input int lab, input bit last);
        int guard;
        if (bp) repeat ($urandom_range(0, 3)) cyc();
        in_x     = 16'(x);
        in_y     = 16'(y);
        in_label = 8'(lab);
        in_last  = last;
        in_valid = 1'b1;
        guard    = 0;
        while (in_ready_a !== 1'b1 && guard < 50) begin
            cyc();
            guard++;
        end
        chk("ready_wait", 64'(guard < 50), 64'd1);
        model_accept(x, y, lab);
        cyc();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int lat;
        lat = 1;
        while (done_a !== 1'b1 && lat < 20) begin
            cyc();
            lat++;
        end
        chk({tag, ".done_lat"}, 64'(lat), 64'd3);
        chk({tag, ".busy"}, 64'(busy_a), 64'd0);
        chk({tag, ".done_b"}, 64'(done_b), 64'd1);
    endtask

    task automatic check_list(input string tag);
        ent_t exp_q[$];
        ent_t e;
        exp_q = model;
        chk({tag, ".count"}, 64'(count_a), 64'(exp_q.size()));
        chk({tag, ".count_b"}, 64'(count_b), 64'(exp_q.size()));
        for (int r = 0; r < K; r++) begin
            rd_sel = 2'(r);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk($sformatf("%s.r%0d.valid", tag, r), 64'(rd_valid_a), 64'd1);
                chk($sformatf("%s.r%0d.dist", tag, r), 64'(rd_dist_a), 64'(e.d));
                chk($sformatf("%s.r%0d.idx", tag, r), 64'(rd_idx_a), 64'(e.idx));
                chk($sformatf("%s.r%0d.label", tag, r), 64'(rd_label_a), 64'(e.lab));
                chk($sformatf("%s.r%0d.dist_b", tag, r), 64'(rd_dist_b), 64'(e.d));
                chk($sformatf("%s.r%0d.idx_b", tag, r), 64'(rd_idx_b), 64'(e.idx_o));
            end else begin
                chk($sformatf("%s.r%0d.valid", tag, r), 64'(rd_valid_a), 64'd0);
                chk($sformatf("%s.r%0d.dist", tag, r), 64'(rd_dist_a), 64'h1_FFFF_FFFF);
                chk($sformatf("%s.r%0d.idx", tag, r), 64'(rd_idx_a), 64'd0);
                chk($sformatf("%s.r%0d.valid_b", tag, r), 64'(rd_valid_b), 64'd0);
            end
        end
        rd_sel = 2'd0;
    endtask

    task automatic check_reset_state(input string tag);
        rd_sel = 2'd0;
        #1;
        chk({tag, ".busy"}, 64'(busy_a), 64'd0);
        chk({tag, ".done"}, 64'(done_a), 64'd0);
        chk({tag, ".in_ready"}, 64'(in_ready_a), 64'd0);
        chk({tag, ".count"}, 64'(count_a), 64'd0);
        chk({tag, ".ovf"}, 64'(ovf_a), 64'd0);
        chk({tag, ".rd_valid"}, 64'(rd_valid_a), 64'd0);
        chk({tag, ".rd_dist"}, 64'(rd_dist_a), 64'h1_FFFF_FFFF);
        chk({tag, ".rd_idx"}, 64'(rd_idx_a), 64'd0);
        chk({tag, ".count_b"}, 64'(count_b), 64'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        test_x   = '0;
        test_y   = '0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_x     = '0;
        in_y     = '0;
        in_label = '0;
        rd_sel   = '0;
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        check_reset_state("reset");

        // Basic sort
        do_start(0, 0);
        chk("basic.busy", 64'(busy_a), 64'd1);
        chk("basic.in_ready", 64'(in_ready_a), 64'd1);
        send(3, 4, 10, 1'b0);
        send(1, 1, 11, 1'b0);
        send(0, 2, 12, 1'b0);
        send(5, 0, 13, 1'b0);
        send(1, 0, 14, 1'b1);
        wait_done("basic");
        check_list("basic");
        rd_sel = 2'd0; #1;
        chk("basic.r0.dist_const", 64'(rd_dist_a), 64'd1);
        chk("basic.r0.idx_const", 64'(rd_idx_a), 64'd4);
        rd_sel = 2'd3; #1;
        chk("basic.r3.dist_const", 64'(rd_dist_a), 64'd25);
        chk("basic.r3.idx_const", 64'(rd_idx_a), 64'd0);
        rd_sel = 2'd0;

        // Ties and partial fill
        do_start(0, 0);
        send(1, 0, 20, 1'b0);
        send(0, 1, 21, 1'b0);
        send(0, -1, 22, 1'b1);
        wait_done("ties");
        check_list("ties");

        // Backpressure and coordinate extremes
        bp = 1;
        do_start(-32768, -32768);
        send(32767, 32767, 30, 1'b0);
        for (int i = 0; i < 3; i++) begin
            send(int'($urandom_range(0, 60000)) - 32768,
                 int'($urandom_range(0, 60000)) - 32768, 31 + i, i == 2);
        end
        wait_done("extreme");
        check_list("extreme");
        rd_sel = 2'd3; #1;
        chk("extreme.max_dist", 64'(rd_dist_a), 64'd8589672450);
        rd_sel = 2'd0;
        bp = 0;

        // Abort mid-stream; the point offered alongside start is dropped
        do_start(0, 0);
        send(5, 5, 40, 1'b0);
        send(6, 6, 41, 1'b0);
        in_x = 16'sd99; in_y = 16'sd99; in_label = 8'd42; in_valid = 1'b1;
        do_start(10, 10);
        in_valid = 1'b0;
        send(10, 10, 43, 1'b0);
        send(11, 10, 44, 1'b1);
        wait_done("abort");
        check_list("abort");

        // Index overflow on the narrow-index instance
        do_start(0, 0);
        for (int i = 0; i < 20; i++) begin
            send(int'($urandom_range(0, 20)) - 10, int'($urandom_range(0, 20)) - 10,
                 50 + i, i == 19);
            if (i == 15) chk("ovf.after16", 64'(ovf_b), 64'd0);
            if (i == 16) chk("ovf.after17", 64'(ovf_b), 64'd1);
        end
        wait_done("ovf");
        check_list("ovf");
        chk("ovf.sticky", 64'(ovf_b), 64'd1);
        chk("ovf.wide_clear", 64'(ovf_a), 64'd0);

        // Asynchronous reset in the middle of a query
        do_start(0, 0);
        send(1, 1, 60, 1'b0);
        send(2, 2, 61, 1'b0);
        #2;
        rst_n = 1'b0;
        check_reset_state("midreset");
        cyc();
        rst_n = 1'b1;
        cyc();
        check_reset_state("postreset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
